// File: rtl/dual_issue_regfile_if.sv
// Write-back, decode-read and debug bus of the dual-issue register file.
// master = pipeline side, slave = register file.
interface dual_issue_regfile_if #(
  parameter int COUNT_WIDTH = 32
);
  logic                   wb_we0, wb_valid0;
  logic [4:0]             wb_addr0;
  logic [31:0]            wb_data0;
  logic                   wb_we1, wb_valid1;
  logic [4:0]             wb_addr1;
  logic [31:0]            wb_data1;
  logic [4:0]             rs0_addr, rt0_addr, rs1_addr, rt1_addr;
  logic [31:0]            rs0_data, rt0_data, rs1_data, rt1_data;
  logic [4:0]             dbg_addr;
  logic [31:0]            dbg_data;
  logic [COUNT_WIDTH-1:0] commit_count;

  modport master (
    output wb_we0, wb_valid0, wb_addr0, wb_data0,
    output wb_we1, wb_valid1, wb_addr1, wb_data1,
    output rs0_addr, rt0_addr, rs1_addr, rt1_addr, dbg_addr,
    input  rs0_data, rt0_data, rs1_data, rt1_data, dbg_data, commit_count
  );

  modport slave (
    input  wb_we0, wb_valid0, wb_addr0, wb_data0,
    input  wb_we1, wb_valid1, wb_addr1, wb_data1,
    input  rs0_addr, rt0_addr, rs1_addr, rt1_addr, dbg_addr,
    output rs0_data, rt0_data, rs1_data, rt1_data, dbg_data, commit_count
  );
endinterface

// File: rtl/dual_issue_regfile.sv
// 32x32 dual-write, quad-read register file with optional WB->ID write-through
// bypass and a retired-slot counter.

// One combinational read lane; younger slot1 write has priority on bypass.
module dual_issue_regfile_rd (
  input  logic [4:0]            addr,
  input  logic [31:0][31:0]     regs,
  input  logic                  bypass_en,
  input  logic [1:0]            we,
  input  logic [1:0][4:0]       wa,
  input  logic [1:0][31:0]      wd,
  output logic [31:0]           data
);
  always_comb begin
    data = regs[addr];
    if (bypass_en) begin
      if (we[1] && wa[1] == addr)      data = wd[1];
      else if (we[0] && wa[0] == addr) data = wd[0];
    end
  end
endmodule

module dual_issue_regfile #(
  parameter int BYPASS      = 1,
  parameter int COUNT_WIDTH = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  dual_issue_regfile_if.slave rf
);
  localparam int NUM_LANES = 4;

  logic [31:1][31:0]                 regs_q;
  logic [31:0][31:0]                 regs_view;
  logic [COUNT_WIDTH-1:0]            cnt_q;
  logic [1:0]                        we;
  logic [1:0][4:0]                   wa;
  logic [1:0][31:0]                  wd;
  logic                              bypass_en;
  logic [NUM_LANES-1:0][4:0]         rd_addr;
  logic [NUM_LANES-1:0][31:0]        rd_data;

  // Writes to $0 never enable, so bypass cannot leak data onto address 0.
  assign we[0] = rf.wb_we0 & rf.wb_valid0 & (|rf.wb_addr0);
  assign we[1] = rf.wb_we1 & rf.wb_valid1 & (|rf.wb_addr1);
  assign wa    = {rf.wb_addr1, rf.wb_addr0};
  assign wd    = {rf.wb_data1, rf.wb_data0};

  // Regs are already zero under reset; only the bypass path needs masking.
  assign bypass_en = (BYPASS != 0) && rst_n;
  assign regs_view = {regs_q, 32'd0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (we[0]) regs_q[wa[0]] <= wd[0];
      if (we[1]) regs_q[wa[1]] <= wd[1];
      cnt_q <= cnt_q + COUNT_WIDTH'(rf.wb_valid0) + COUNT_WIDTH'(rf.wb_valid1);
    end
  end

  assign rd_addr = {rf.rt1_addr, rf.rs1_addr, rf.rt0_addr, rf.rs0_addr};

  generate
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_rd
      dual_issue_regfile_rd u_rd (
        .addr      (rd_addr[g]),
        .regs      (regs_view),
        .bypass_en (bypass_en),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .data      (rd_data[g])
      );
    end
  endgenerate

  assign rf.rs0_data     = rd_data[0];
  assign rf.rt0_data     = rd_data[1];
  assign rf.rs1_data     = rd_data[2];
  assign rf.rt1_data     = rd_data[3];
  assign rf.dbg_data     = regs_view[rf.dbg_addr];
  assign rf.commit_count = cnt_q;
endmodule

// File: doc/dual_issue_regfile.md
Name: dual_issue_regfile

Overview:
- Architectural 32x32 general-purpose register file for the dual-issue MIPS pipeline.
- Written at WB by both MEM/WB slots (slot0 older, slot1 younger).
- Read combinationally in ID by both decode slots (rs/rt each). Read data is the `current_data` input of the ID-stage forwarding units.
- Optional same-cycle write-through bypass closes the WB-to-ID gap that the forwarding units do not cover.
- Keeps a committed-write counter for debug and trace.

Parameters:
- BYPASS, 1, 1 = read ports return same-cycle WB write data; 0 = reads see only registered state.
- COUNT_WIDTH, 32, width of commit_count.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wb_we0  input  1  slot0 reg_write (ctrl0.reg_write).
- wb_valid0  input  1  slot0 MEM/WB valid.
- wb_addr0  input  5  slot0 destination register.
- wb_data0  input  32  slot0 write data.
- wb_we1  input  1  slot1 reg_write.
- wb_valid1  input  1  slot1 MEM/WB valid.
- wb_addr1  input  5  slot1 destination register.
- wb_data1  input  32  slot1 write data.
- rs0_addr  input  5  decode slot0 rs.
- rt0_addr  input  5  decode slot0 rt.
- rs1_addr  input  5  decode slot1 rs.
- rt1_addr  input  5  decode slot1 rt.
- rs0_data  output  32  read data for rs0_addr.
- rt0_data  output  32  read data for rt0_addr.
- rs1_data  output  32  read data for rs1_addr.
- rt1_data  output  32  read data for rt1_addr.
- dbg_addr  input  5  debug read address.
- dbg_data  output  32  registered state at dbg_addr; never bypassed.
- commit_count  output  COUNT_WIDTH  number of valid WB slots retired since reset.

Behaviour:
- Effective write enable: weN = wb_weN & wb_validN & (wb_addrN != 0).
- Register updates:
  - On posedge, if we0, regs[wb_addr0] <= wb_data0.
  - On posedge, if we1, regs[wb_addr1] <= wb_data1.
  - Same address on both slots: slot1 (younger) wins; slot0 data is discarded.
- Register 0 is never stored. Every read of address 0 returns 0, including via bypass.
- Read ports are purely combinational, with zero-cycle latency from address to data.
- Bypass, applied per read port with address A != 0 when BYPASS=1:
  - If we1 and wb_addr1==A, return wb_data1.
  - Else if we0 and wb_addr0==A, return wb_data0.
  - Else return regs[A].
- With BYPASS=0, reads return regs[A]; a write becomes visible the cycle after the edge.
- dbg_data = regs[dbg_addr], or 0 for address 0. No bypass.
- commit_count:
  - On posedge, increments by (wb_valid0 + wb_valid1), i.e. 0, 1 or 2.
  - Counts regardless of reg_write, so stores, branches and writes to $0 are counted.
  - Wraps modulo 2^COUNT_WIDTH with no saturation.
- Reset: rst_n low asynchronously clears all regs[1..31] and commit_count to 0.
  - While rst_n is low, all four read outputs and dbg_data are 0 and bypass is suppressed.
  - Reset asserted mid-cycle with a pending write: the write is lost, and the register reads 0 after reset.
  - First write takes effect on the first rising edge with rst_n high.
- Invalid slot (wb_validN=0) with wb_weN=1: no write and no bypass.
- The block has no stall input. Stalls are handled upstream, since MEM/WB valid drops on bubbles.

Test Plan:
- Reset, then read all 31 registers via dbg -> all 0; commit_count=0.
- Slot0 writes r5=0x1234_5678, valid0=1; same cycle rs0_addr=5 -> rs0_data=0x1234_5678 via bypass (BYPASS=1). Next cycle dbg r5=0x1234_5678; commit_count=1.
- Both slots write r7 (slot0 0xAAAA_0000, slot1 0x0000_BBBB) -> same-cycle rt1_data=0x0000_BBBB; after edge r7=0x0000_BBBB; commit_count +2.
- Write to r0 with data 0xFFFF_FFFF -> rs0_data for addr 0 is 0 both same cycle and next; dbg r0=0; commit_count still +1.
- wb_we1=1, wb_valid1=0, addr 9, data 0xDEAD_BEEF -> no bypass, r9 unchanged. Then BYPASS=0 build: write r3=0x42 -> same-cycle read returns old value, next cycle 0x42.
- Preload r12=0x55; assert rst_n low between edges while a write to r12=0x99 is pending -> r12=0 and commit_count=0 immediately. Also: preset commit_count to all-ones via 2^32-1 valid retirements (or a COUNT_WIDTH=4 build) -> wraps to 0/1 correctly.
